// File: rtl/perf_event_counter_bank.sv
// Performance event counter bank: counts pipeline event strobes and cycles
// between start and halt, freezes on halt, and exposes counts on a registered read port.
module perf_event_counter_bank #(
  parameter int unsigned NUM_EVT  = 6,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SAT_MODE = 1,
  parameter int unsigned SEL_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clear,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [NUM_EVT:0]   overflow,
  output logic               frozen,
  output logic               done
);

  localparam int unsigned NUM_CNT = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_CNT-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CNT-1:0]              ovf_q, ovf_d;
  logic [CNT_W-1:0]                rd_data_q, rd_data_d;
  logic                            frozen_q, frozen_d;
  logic                            done_q, done_d;
  logic                            count_en;
  logic [NUM_CNT-1:0]              inc;

  // Cycle counter sits at index NUM_EVT and increments on every counting cycle.
  assign inc = {1'b1, evt};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    count_en  = 1'b0;
    rd_data_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        count_en = 1'b1;
        if (halt) begin
          state_d = ST_FROZEN;
          done_d  = 1'b1;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_FROZEN: begin
        state_d = ST_FROZEN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (count_en) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (inc[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_d[i] = 1'b1;
            cnt_d[i] = (SAT_MODE != 0) ? CNT_MAX : '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end

    // Clear wins over halt and events arriving in the same cycle.
    if (clear) begin
      state_d = enable ? ST_RUN : ST_IDLE;
      cnt_d   = '0;
      ovf_d   = '0;
      done_d  = 1'b0;
    end

    frozen_d = (state_d == ST_FROZEN);

    // Read mux samples pre-increment values; out-of-range selects return zero.
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data_d = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      frozen_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      frozen_q  <= frozen_d;
      done_q    <= done_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign cycle_count = cnt_q[NUM_EVT];
  assign overflow    = ovf_q;
  assign frozen      = frozen_q;
  assign done        = done_q;

endmodule
